// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the boot loader (ld), CPU data port (d) and
// CPU fetch (f). Each access runs IDLE -> ISSUE -> [WAIT] -> DONE with a one-cycle ack.
module mem_port_arbiter #(
  parameter int DW         = 19,
  parameter int AW         = 19,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          ld_ack,
  output logic          d_ack,
  output logic          f_ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    state_dbg
);

  // Handshake: a requester raises *_req with its payload and holds both stable until
  // its one-cycle *_ack; requests and payloads are only looked at while in IDLE.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] win;         // one-hot {ld, d, f} owner of the current access
  logic [2:0] lat_cnt;
  logic [2:0] starve_cnt;
  logic       grant_ld;
  logic       grant_d;
  logic       grant_f;

  // ld always wins; between d and f, fetch only wins once it has lost STARVE_MAX times
  always_comb begin
    grant_ld = ld_req;
    grant_d  = 1'b0;
    grant_f  = 1'b0;
    if (!ld_req) begin
      if (d_req && f_req) begin
        grant_f = (starve_cnt == 3'(STARVE_MAX));
        grant_d = !grant_f;
      end else begin
        grant_d = d_req;
        grant_f = f_req;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      win        <= 3'b000;
      lat_cnt    <= 3'd0;
      starve_cnt <= 3'd0;
      ld_ack     <= 1'b0;
      d_ack      <= 1'b0;
      f_ack      <= 1'b0;
      rdata      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_req || d_req || f_req) begin
            state  <= S_ISSUE;
            mem_en <= 1'b1;
            win    <= {grant_ld, grant_d, grant_f};
            if (grant_ld) begin
              mem_we    <= ld_we;
              mem_addr  <= ld_addr;
              mem_wdata <= ld_wdata;
            end else if (grant_d) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= f_addr;
            end
            if (f_req) begin
              if (grant_f) begin
                starve_cnt <= 3'd0;
              end else if (starve_cnt != 3'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 3'd1;
              end
            end
          end
        end
        S_ISSUE: begin
          // mem_we still carries the latched direction during ISSUE
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (mem_we) begin
            state                  <= S_DONE;
            {ld_ack, d_ack, f_ack} <= win;
          end else begin
            lat_cnt <= 3'(RD_LAT);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            rdata                  <= mem_rdata;
            state                  <= S_DONE;
            {ld_ack, d_ack, f_ack} <= win;
          end
        end
        S_DONE: begin
          {ld_ack, d_ack, f_ack} <= 3'b000;
          state                  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for arbitration and latency,
// plus hand sequences for reset abort, grant ordering, starvation and read-after-write.
module tb_mem_port_arbiter;
  localparam int DW = 19;
  localparam int AW = 19;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- DUT (RD_LAT = 1) ----------------
  logic          ld_req, ld_we, d_req, d_we, f_req;
  logic [AW-1:0] ld_addr, d_addr, f_addr;
  logic [DW-1:0] ld_wdata, d_wdata;
  logic          ld_ack, d_ack, f_ack, busy, mem_en, mem_we;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    state_dbg;

  mem_port_arbiter #(.DW(DW), .AW(AW), .RD_LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .f_req(f_req), .f_addr(f_addr),
    .ld_ack(ld_ack), .d_ack(d_ack), .f_ack(f_ack),
    .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // ---------------- DUT (RD_LAT = 3), fetch only ----------------
  logic          f3_req;
  logic [AW-1:0] f3_addr;
  logic          ld_ack3, d_ack3, f_ack3, busy3, mem_en3, mem_we3;
  logic [DW-1:0] rdata3, mem_wdata3, mem_rdata3;
  logic [AW-1:0] mem_addr3;
  logic [1:0]    state_dbg3;

  mem_port_arbiter #(.DW(DW), .AW(AW), .RD_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .reset(reset),
    .ld_req(1'b0), .ld_we(1'b0), .ld_addr('0), .ld_wdata('0),
    .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
    .f_req(f3_req), .f_addr(f3_addr),
    .ld_ack(ld_ack3), .d_ack(d_ack3), .f_ack(f_ack3),
    .rdata(rdata3), .busy(busy3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .state_dbg(state_dbg3)
  );

  // ---------------- memory model (shared array, per-DUT read pipelines) ----------------
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_p1;
  logic [DW-1:0] rd3_p [0:2];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    rd_p1    <= mem_en ? mem[mem_addr[7:0]] : '0;
    rd3_p[0] <= mem_en3 ? mem[mem_addr3[7:0]] : '0;
    rd3_p[1] <= rd3_p[0];
    rd3_p[2] <= rd3_p[1];
  end
  assign mem_rdata  = rd_p1;
  assign mem_rdata3 = rd3_p[2];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic l, input logic d, input logic f, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    ld_req = l; d_req = d; f_req = f;
    ld_we = we; d_we = we;
    ld_addr = addr; d_addr = addr; f_addr = addr;
    ld_wdata = wdata; d_wdata = wdata;
  endtask

  task automatic clear_req;
    ld_req = 1'b0; d_req = 1'b0; f_req = 1'b0;
  endtask

  // Waits (bounded) for any ack; lat counts cycles from the request-seen cycle.
  task automatic wait_ack(output logic [2:0] acks, output int lat, output int en_cnt);
    acks = 3'b000; lat = 0; en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      lat++;
      if (mem_en) en_cnt++;
      acks = {ld_ack, d_ack, f_ack};
      if (acks != 3'b000) break;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          ld, d, f, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    exp_ack;
    int            exp_lat;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [2:0] acks;
    int lat, en_cnt, multi, hit_we;
    int got_cnt;
    logic [DW-1:0] f_rd;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 19'h00004, 19'h12345, 3'b100, 2, 19'h00000};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 19'h00004, 19'h00000, 3'b001, 3, 19'h12345};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 19'h00030, 19'h11111, 3'b100, 2, 19'h12345};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 19'h00030, 19'h00000, 3'b100, 3, 19'h11111};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 19'h00040, 19'h22222, 3'b010, 2, 19'h11111};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 19'h00040, 19'h00000, 3'b010, 3, 19'h22222};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 19'h00010, 19'h00000, 3'b010, 3, 19'h7FFFF};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 19'h00004, 19'h00000, 3'b001, 3, 19'h12345};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 19'h00040, 19'h00000, 3'b100, 3, 19'h22222};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 19'h00030, 19'h00000, 3'b010, 3, 19'h11111};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 19'h00010, 19'h00000, 3'b010, 3, 19'h7FFFF};

    reset = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    f3_req = 1'b0; f3_addr = '0;
    tick; tick;
    check("rst_mem_en", mem_en, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_acks", {ld_ack, d_ack, f_ack}, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b1;
    tick;

    // single data-port write, cycle by cycle
    set_req(1'b0, 1'b1, 1'b0, 1'b1, 19'h00010, 19'h7FFFF);
    check("t1_idle_busy", busy, 0);
    tick;
    check("t1_issue_en", mem_en, 1);
    check("t1_issue_we", mem_we, 1);
    check("t1_issue_addr", mem_addr, 19'h00010);
    check("t1_issue_wdata", mem_wdata, 19'h7FFFF);
    check("t1_issue_busy", busy, 1);
    check("t1_issue_acks", {ld_ack, d_ack, f_ack}, 3'b000);
    tick;
    check("t1_done_acks", {ld_ack, d_ack, f_ack}, 3'b010);
    check("t1_done_en", mem_en, 0);
    check("t1_done_we", mem_we, 0);
    check("t1_done_busy", busy, 1);
    clear_req;
    tick;
    check("t1_idle_acks", {ld_ack, d_ack, f_ack}, 3'b000);
    check("t1_idle_busy2", busy, 0);
    check("t1_addr_hold", mem_addr, 19'h00010);

    // table-driven arbitration / latency / data vectors
    foreach (vecs[k]) begin
      set_req(vecs[k].ld, vecs[k].d, vecs[k].f, vecs[k].we, vecs[k].addr, vecs[k].wdata);
      wait_ack(acks, lat, en_cnt);
      check($sformatf("vec%0d_ack", k), acks, vecs[k].exp_ack);
      check($sformatf("vec%0d_lat", k), lat, vecs[k].exp_lat);
      check($sformatf("vec%0d_rdata", k), rdata, vecs[k].exp_rdata);
      check($sformatf("vec%0d_en_cnt", k), en_cnt, 1);
      clear_req;
      tick;
      check($sformatf("vec%0d_idle", k), {busy, ld_ack, d_ack, f_ack}, 4'b0000);
    end

    // RD_LAT = 3 fetch
    f3_req = 1'b1; f3_addr = 19'h00004;
    lat = 0; hit_we = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      lat++;
      if (mem_we3) hit_we++;
      if (f_ack3) break;
    end
    check("lat3_ack", {ld_ack3, d_ack3, f_ack3}, 3'b001);
    check("lat3_lat", lat, 5);
    check("lat3_rdata", rdata3, 19'h12345);
    check("lat3_no_we", hit_we, 0);
    f3_req = 1'b0;
    tick;

    // reset asserted in WAIT of a read
    set_req(1'b0, 1'b0, 1'b1, 1'b0, 19'h00040, '0);
    tick; tick;
    check("t5_in_wait", state_dbg, 2'd2);
    reset = 1'b0;
    #1;
    check("t5_en", mem_en, 0);
    check("t5_acks", {ld_ack, d_ack, f_ack}, 0);
    check("t5_rdata", rdata, 0);
    check("t5_busy", busy, 0);
    clear_req;
    tick; tick;
    reset = 1'b1;
    got_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (busy || ld_ack || d_ack || f_ack || mem_en) got_cnt++;
    end
    check("t5_quiet_after", got_cnt, 0);

    // all three at once, each holds until its own ack
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 19'h00050; ld_wdata = 19'h33333;
    d_req = 1'b1; d_we = 1'b1; d_addr = 19'h00051; d_wdata = 19'h44444;
    f_req = 1'b1; f_addr = 19'h00050;
    exp_q.push_back(3'b100); exp_q.push_back(3'b010); exp_q.push_back(3'b001);
    multi = 0; got_cnt = 0; f_rd = '0;
    for (int i = 0; i < 40 && got_cnt < 3; i++) begin
      tick;
      acks = {ld_ack, d_ack, f_ack};
      if ($countones(acks) > 1) multi++;
      if (acks != 3'b000) begin
        got_cnt++;
        if (exp_q.size() > 0) check("t3_order", acks, exp_q.pop_front());
        if (ld_ack) ld_req = 1'b0;
        if (d_ack) d_req = 1'b0;
        if (f_ack) begin f_req = 1'b0; f_rd = rdata; end
      end
    end
    check("t3_grants", got_cnt, 3);
    check("t3_multi_ack", multi, 0);
    check("t3_f_rdata", f_rd, 19'h33333);
    exp_q.delete();
    clear_req;
    tick;

    // starvation guard: d and f held continuously
    set_req(1'b0, 1'b1, 1'b1, 1'b1, 19'h00060, 19'h55555);
    f_addr = 19'h00004;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) exp_q.push_back(3'b010);
      exp_q.push_back(3'b001);
    end
    while (exp_q.size() > 0) begin
      wait_ack(acks, lat, en_cnt);
      check("t4_grant", acks, exp_q.pop_front());
    end
    clear_req;
    tick;
    check("t4_last_rdata", rdata, 19'h12345);

    // back-to-back write then read of the same address
    set_req(1'b0, 1'b1, 1'b0, 1'b1, 19'h00020, 19'h00ABC);
    wait_ack(acks, lat, en_cnt);
    check("t6_wr_ack", acks, 3'b010);
    check("t6_wr_rdata_kept", rdata, 19'h12345);
    clear_req;
    tick;
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 19'h00020, '0);
    wait_ack(acks, lat, en_cnt);
    check("t6_rd_ack", acks, 3'b010);
    check("t6_rd_rdata", rdata, 19'h00ABC);
    clear_req;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Single-transaction arbiter that shares one single-ported 19-bit memory between three requesters: the boot loader (ld), the CPU data port (d) and the CPU instruction fetch (f).
- Sits between CPU_19_bit and the memory macro.
- Sequences each access through a fixed ISSUE/WAIT/DONE flow and returns a one-cycle ack to the winning requester.
- Fixed priority is ld > d > f, with a starvation guard that protects fetch from the data port.

Parameters:
DW, 19, data width
AW, 19, address width
RD_LAT, 1, memory read latency in cycles after the mem_en cycle; legal range 1..7
STARVE_MAX, 4, number of consecutive lost arbitrations after which fetch beats d; legal range 1..7

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
ld_req  in  1  loader request; held until ld_ack
ld_we  in  1  loader write enable (1 = write, 0 = read)
ld_addr  in  AW  loader address
ld_wdata  in  DW  loader write data
d_req  in  1  data-port request; held until d_ack
d_we  in  1  data-port write enable
d_addr  in  AW  data-port address
d_wdata  in  DW  data-port write data
f_req  in  1  fetch request (read only); held until f_ack
f_addr  in  AW  fetch address
ld_ack, d_ack, f_ack  out  1 each  one-cycle transaction-complete pulse
rdata  out  DW  read data; valid only while the owning *_ack is high
busy  out  1  high in every state except IDLE
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid RD_LAT cycles after the mem_en cycle

Behaviour:
- Reset (asynchronous, active-low): takes effect immediately, mid-transaction included.
  - State goes to IDLE.
  - mem_en, mem_we and all acks go to 0.
  - mem_addr, mem_wdata and rdata go to 0.
  - Starvation counter and latency counter go to 0.
  - busy goes to 0.
  - An aborted transaction never acks.
- States:
  - IDLE: evaluate requests combinationally. If any request is high, latch winner id, we, addr and wdata, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: exactly one cycle. Drive mem_en=1, mem_we=latched we, mem_addr and mem_wdata from the latches. Fetch always uses we=0. On a write, go to DONE. On a read, load the latency counter with RD_LAT and go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, register mem_rdata into rdata and go to DONE.
  - DONE: exactly one cycle. Assert the winner's *_ack and only that one, then go to IDLE. rdata holds its value until the next read capture; write transactions leave rdata unchanged.
- mem_en is 1 only in ISSUE. mem_we is 0 outside ISSUE. mem_addr and mem_wdata hold their last value outside ISSUE.
- Latency, with the request first seen in IDLE at cycle t:
  - Write: ISSUE at t+1, ack at t+2.
  - Read: ISSUE at t+1, rdata captured at edge t+1+RD_LAT, ack at t+2+RD_LAT.
- Minimum one IDLE cycle between transactions. Peak throughput is one write per 3 cycles.
- Requesters must keep req and payload stable until ack, and deassert req in the cycle after ack unless they are starting a new access. Requests are ignored outside IDLE, and the payload is sampled only in IDLE.
- Arbitration in IDLE:
  - If ld_req, ld wins.
  - Else if d_req and f_req: f wins if starve_cnt == STARVE_MAX, else d wins.
  - Else the single requester wins.
- starve_cnt (3 bits):
  - Increments, saturating at STARVE_MAX, on each IDLE arbitration where f_req=1 and f loses.
  - Clears when f wins.
  - Loader wins also increment it, but the guard never overrides ld.
- Simultaneous events: ld+d+f all high gives ld. A new request arriving in DONE is seen in the following IDLE.

Test Plan:
1. Reset release, then d_req=1, d_we=1, d_addr=19'h00010, d_wdata=19'h7FFFF -> mem_en=1/mem_we=1/mem_addr=0x10/mem_wdata=0x7FFFF exactly one cycle, d_ack pulses 2 cycles after the request is seen, busy high during ISSUE/DONE.
2. RD_LAT=1 and RD_LAT=3: f_req=1, f_addr=0x00004, memory model returns 0x12345 -> f_ack at t+3 (resp. t+5) with rdata=0x12345; mem_we=0 throughout.
3. ld_req, d_req and f_req all asserted together (each holds req until its ack) -> grant order ld, d, f; exactly one ack per DONE; no two acks in the same cycle.
4. STARVE_MAX=4, d_req and f_req held continuously -> d wins 4 times, f wins the 5th arbitration, d wins the next 4, and the pattern repeats.
5. Assert reset (0) during WAIT of a read -> mem_en=0, all acks 0, rdata=0 and busy=0 immediately; after release with no requests, the arbiter stays in IDLE and no stale ack appears.
6. Back-to-back: d writes 0x00ABC to address 0x00020, then d reads address 0x00020 with the memory model connected -> second ack returns rdata=0x00ABC; rdata is unchanged after the write ack.
